// File: rtl/mem_stage.sv
// MEM pipeline stage: latches EX results, waits for the data-SRAM response, aligns load data for WB.
// Optional MS_STALL_CNT_EN adds the ms_stall_cycles counter output.
module mem_stage (
  input  logic        clk,
  input  logic        resetn,
  input  logic        es_to_ms_valid,
  output logic        ms_allowin,
  input  logic [31:0] es_pc,
  input  logic [37:0] es_rf_collect,
  input  logic [4:0]  es_ld_op,
  input  logic        es_mem_req,
  input  logic [6:0]  es_to_ms_bus,
  input  logic        data_sram_data_ok,
  input  logic [31:0] data_sram_rdata,
  input  logic        ws_allowin,
  output logic        ms_to_ws_valid,
  output logic [31:0] ms_pc,
  output logic [37:0] ms_rf_collect,
  output logic [6:0]  ms_to_ws_bus,
  output logic [38:0] ms_rf_fwd,
  output logic        ms_ex_pending,
  input  logic        wb_ex,
  input  logic        ertn_flush
`ifdef MS_STALL_CNT_EN
  ,
  output logic [31:0] ms_stall_cycles
`endif
);

  logic        vld_p1;
  logic [31:0] pc_p1;
  logic [37:0] rf_p1;
  logic [4:0]  ld_op_p1;
  logic        mem_req_p1;
  logic [6:0]  ex_p1;
  logic        discard;
  logic        rbuf_valid;
  logic [31:0] rbuf;

  logic        flush;
  logic        ready_go;
  logic        resp_ok;
  logic        to_ws_fire;
  logic        accept;
  logic [31:0] rdata_eff;
  logic [31:0] wdata;

  // ld_op is one-hot {ld_b, ld_bu, ld_h, ld_hu, ld_w}
  function automatic logic [31:0] load_align(input logic [4:0]  op,
                                             input logic [1:0]  addr,
                                             input logic [31:0] rdata);
    logic        [7:0]  b;
    logic        [15:0] h;
    logic signed [31:0] bs;
    logic signed [31:0] hs;
    case (addr)
      2'd0:    b = rdata[7:0];
      2'd1:    b = rdata[15:8];
      2'd2:    b = rdata[23:16];
      default: b = rdata[31:24];
    endcase
    h  = addr[1] ? rdata[31:16] : rdata[15:0];
    bs = 32'(signed'(b));
    hs = 32'(signed'(h));
    case (1'b1)
      op[4]:   load_align = bs;
      op[3]:   load_align = {24'd0, b};
      op[2]:   load_align = hs;
      op[1]:   load_align = {16'd0, h};
      default: load_align = rdata;
    endcase
  endfunction

  assign flush      = wb_ex | ertn_flush;
  assign ready_go   = ~mem_req_p1 | rbuf_valid | (data_sram_data_ok & ~discard);
  assign resp_ok    = vld_p1 & mem_req_p1 & ~rbuf_valid & data_sram_data_ok & ~discard;
  assign ms_allowin = ~vld_p1 | (ready_go & ws_allowin);
  assign ms_to_ws_valid = vld_p1 & ready_go;
  assign to_ws_fire = ms_to_ws_valid & ws_allowin;
  assign accept     = es_to_ms_valid & ms_allowin;

  // EX -> MS boundary
  always_ff @(posedge clk) begin
    if (!resetn) begin
      vld_p1 <= 1'b0;
    end else if (flush) begin
      vld_p1 <= 1'b0;
    end else if (ms_allowin) begin
      vld_p1 <= es_to_ms_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      pc_p1      <= 32'd0;
      rf_p1      <= 38'd0;
      ld_op_p1   <= 5'd0;
      mem_req_p1 <= 1'b0;
      ex_p1      <= 7'd0;
    end else if (accept) begin
      pc_p1      <= es_pc;
      rf_p1      <= es_rf_collect;
      ld_op_p1   <= es_ld_op;
      mem_req_p1 <= es_mem_req;
      ex_p1      <= es_to_ms_bus;
    end
  end

  // A flushed request still owes one response; it must not satisfy whatever comes next.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      discard <= 1'b0;
    end else if (discard & data_sram_data_ok) begin
      discard <= 1'b0;
    end else if (flush & vld_p1 & mem_req_p1 & ~rbuf_valid & ~data_sram_data_ok) begin
      discard <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rbuf_valid <= 1'b0;
    end else if (flush | to_ws_fire) begin
      rbuf_valid <= 1'b0;
    end else if (resp_ok & ~ws_allowin) begin
      rbuf_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (resp_ok & ~ws_allowin & ~rbuf_valid) begin
      rbuf <= data_sram_rdata;
    end
  end

`ifdef MS_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ms_stall_cycles <= 32'd0;
    end else if (vld_p1 & ~ready_go) begin
      ms_stall_cycles <= ms_stall_cycles + 32'd1;
    end
  end
`endif

  // MS -> WB boundary
  assign rdata_eff = rbuf_valid ? rbuf : data_sram_rdata;
  assign wdata     = (|ld_op_p1) ? load_align(ld_op_p1, rf_p1[1:0], rdata_eff) : rf_p1[31:0];

  assign ms_pc         = pc_p1;
  assign ms_rf_collect = {rf_p1[37:32], wdata};
  assign ms_to_ws_bus  = ex_p1;
  assign ms_rf_fwd     = {vld_p1 & (|ld_op_p1) & ~ready_go, rf_p1[37] & vld_p1, rf_p1[36:32], wdata};
  assign ms_ex_pending = vld_p1 & (|ex_p1);

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM pipeline stage of the LoongArch 5-stage core; sits between EX and WB stages.
- Latches EX results and waits for the data-SRAM response of an issued load/store.
- Aligns and sign/zero-extends load data, then hands {we, waddr, wdata}, PC and the exception vector to WB over a valid/allowin handshake.
- Exports a forwarding/load-use bus to ID and an exception-pending flag to EX; absorbs flushes from WB.

Parameters:
- none

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- es_to_ms_valid  in  1  EX holds a valid instruction for MS
- ms_allowin  out  1  MS can accept from EX this cycle
- es_pc  in  32  EX instruction PC
- es_rf_collect  in  38  {we, waddr[4:0], alu_result[31:0]}
- es_ld_op  in  5  one-hot {ld_b, ld_bu, ld_h, ld_hu, ld_w}; all-zero = not a load
- es_mem_req  in  1  EX issued a data-SRAM request (load or store) for this instruction
- es_to_ms_bus  in  7  {ale, adef, ine, syscall, brk, int, ertn}
- data_sram_data_ok  in  1  data-SRAM response strobe
- data_sram_rdata  in  32  response data
- ws_allowin  in  1  WB can accept
- ms_to_ws_valid  out  1  MS result valid to WB
- ms_pc  out  32  latched PC
- ms_rf_collect  out  38  {we, waddr, wdata}, wdata = load result or alu_result
- ms_to_ws_bus  out  7  latched exception vector, same bit order as es_to_ms_bus
- ms_rf_fwd  out  39  {ms_is_load_pending, we & ms_valid, waddr, wdata} to ID
- ms_ex_pending  out  1  ms_valid & (|ms_to_ws_bus); EX must suppress memory requests
- wb_ex  in  1  WB exception flush
- ertn_flush  in  1  WB ertn flush

Behaviour:
- Reset (resetn=0 at posedge): ms_valid=0, all latched fields=0, discard=0, rbuf_valid=0. Outputs after reset: ms_allowin=1, ms_to_ws_valid=0, ms_pc=0, ms_rf_collect=0, ms_to_ws_bus=0, ms_rf_fwd=0, ms_ex_pending=0.
- Handshake:
  - ms_allowin = ~ms_valid | (ms_ready_go & ws_allowin).
  - ms_to_ws_valid = ms_valid & ms_ready_go.
  - Latch on es_to_ms_valid & ms_allowin: pc, rf_collect, ld_op, mem_req, exception bus.
- ms_valid update:
  - flush = wb_ex | ertn_flush. flush -> 0 (highest priority after reset).
  - Otherwise, when ms_allowin: ms_valid <= es_to_ms_valid.
- Response tracking (one outstanding request max):
  - ms_ready_go = ~ms_mem_req | rbuf_valid | (data_ok & ~discard).
  - Zero-latency case: data_ok in the same cycle MS holds the request gives ready_go=1 that cycle.
  - Buffering: if data_ok arrives (not discarded) but ws_allowin=0, capture rdata into rbuf and set rbuf_valid. rbuf_valid clears when the instruction moves to WB.
  - Effective rdata = rbuf_valid ? rbuf : data_sram_rdata.
- Flush with a request outstanding:
  - Condition: ms_valid & ms_mem_req & ~rbuf_valid & ~data_ok.
  - Action: set discard=1. The next data_ok is consumed and dropped, clearing discard; it does not satisfy a newly latched request.
  - data_ok and flush in the same cycle: the response is dropped and discard is not set.
  - A new request in MS while discard=1 stalls (ready_go=0) until discard clears.
- Load data formation (addr[1:0] = alu_result[1:0]):
  - ld_w: full word.
  - ld_b / ld_bu: byte addr[1:0], sign- or zero-extended to 32 bits.
  - ld_h / ld_hu: half addr[1], sign- or zero-extended to 32 bits.
  - Stores and non-memory instructions pass alu_result through.
- ms_rf_fwd[38] = ms_valid & (|ld_op) & ~ms_ready_go. ID stalls on a RAW hazard against a pending load.
- Exceptions: a latched nonzero bus is propagated unchanged. EX guarantees es_mem_req=0 when the bus is nonzero.

Optional Feature:
- Macro: MS_STALL_CNT_EN.
- Defined:
  - Adds output ms_stall_cycles [31:0], reset 0.
  - Increments each cycle ms_valid & ~ms_ready_go; wraps at 2^32-1 -> 0; unaffected by flush.
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- ld_w at alu_result=0x100, data_ok 2 cycles after latch with rdata=0xDEADBEEF -> ms_to_ws_valid=0 for 2 cycles (fwd[38]=1), then 1 cycle with ms_rf_collect={1, waddr, 0xDEADBEEF}.
- ld_b addr[1:0]=2'b11, rdata=0x80FF_0000 -> wdata=0xFFFFFF80; ld_bu same -> 0x00000080; ld_h addr=2'b10 -> 0xFFFF80FF; ld_hu -> 0x000080FF.
- data_ok=1 while ws_allowin=0 for 3 cycles, rdata then changes to 0x0 -> WB receives buffered 0x12345678 once ws_allowin=1; ms_allowin=0 during the hold.
- Load in MS, wb_ex pulses before data_ok; next ld_w latched; two data_ok pulses (0xAAAA0000, then 0x0000BBBB) -> first dropped, WB gets 0x0000BBBB.
- syscall instruction (bus=7'b0001000) with es_mem_req=0 -> ms_ex_pending=1 while valid, forwarded next cycle with ms_to_ws_bus=7'b0001000.
- resetn=0 mid-wait with discard=1 -> all outputs 0, ms_allowin=1, discard cleared.
